// File: rtl/prog_loader_if.sv
// Program-word stream between a program source (master) and prog_loader (slave).
interface prog_loader_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/prog_loader.sv
// Program load / run-control engine: streams a program into instruction memory, then runs the
// processor under a watchdog. Define PROG_LOADER_HALT_DETECT_EN to end runs on repeated halt fetches.
module prog_loader #(
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 32,
  parameter int              PROG_DEPTH  = 1024,
  parameter int              RUN_CYCLES  = 100,
  parameter logic [DATA_W-1:0] HALT_WORD = '0,
  parameter int              HALT_REPEAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  prog_loader_if.slave        prog,
  output logic                mem_w,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  output logic                cpu_rst,
  input  logic [DATA_W-1:0]   cpu_insn,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [ADDR_W-1:0]   words_loaded,
  output logic [31:0]         cycles
);

  typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, DONE} state_t;
  state_t state;

  logic        beat;
  logic        last_beat;
  logic [31:0] cycles_inc;
  logic        wd_hit;
  logic        halt_hit;

  assign prog.s_ready = (state == LOAD);
  assign beat         = prog.s_valid && prog.s_ready;
  assign last_beat    = prog.s_last || (words_loaded == ADDR_W'(PROG_DEPTH - 1));
  assign cycles_inc   = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
  assign wd_hit       = (cycles_inc == 32'(RUN_CYCLES));

`ifdef PROG_LOADER_HALT_DETECT_EN
  localparam int HC_W    = $clog2(HALT_REPEAT + 1);
  localparam bit WD_FLAG = 1'b1;
  logic [HC_W-1:0] halt_cnt;
  logic            is_halt;
  assign is_halt  = (cpu_insn == HALT_WORD);
  assign halt_hit = is_halt && (halt_cnt == HC_W'(HALT_REPEAT - 1));

  always_ff @(posedge clk) begin
    if (rst || state != RUN || !cpu_rst && !is_halt) halt_cnt <= '0;
    else if (!cpu_rst)                               halt_cnt <= halt_cnt + HC_W'(1);
  end
`else
  // Without halt detection every run is fixed-length, so reaching the limit is normal completion.
  localparam bit WD_FLAG = 1'b0;
  logic unused_halt;
  assign unused_halt = ^{cpu_insn, HALT_WORD, 32'(HALT_REPEAT)};
  assign halt_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_w        <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      words_loaded <= '0;
      cycles       <= '0;
    end else begin
      mem_w <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state        <= LOAD;
          busy         <= 1'b1;
          done         <= 1'b0;
          timeout      <= 1'b0;
          words_loaded <= '0;
          cycles       <= '0;
        end
        LOAD: if (beat) begin
          mem_w        <= 1'b1;
          mem_addr     <= words_loaded;
          mem_data     <= prog.s_data;
          words_loaded <= words_loaded + ADDR_W'(1);
          if (last_beat) state <= RELEASE;
        end
        RELEASE: state <= RUN;
        RUN: begin
          // First RUN edge only lifts processor reset; counting starts once it is fetching.
          if (cpu_rst) cpu_rst <= 1'b0;
          else begin
            cycles <= cycles_inc;
            if (halt_hit || wd_hit) begin
              state   <= DONE;
              done    <= 1'b1;
              timeout <= WD_FLAG && !halt_hit;
              cpu_rst <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Parametrised program-load and run-control engine for the single-cycle processor. It streams a program into instruction memory over a valid/ready handshake while holding the processor in reset, then releases it. It runs the processor under a cycle watchdog, detects program end, and reports done/timeout status. It replaces hard-coded `bank[]` preloading and fixed-delay finishes, and sits between a program source, the `memory` write port and `processor_p`.

## Interface
- `DATA_W`, 32, instruction word width
- `ADDR_W`, 32, memory address width (word index, as `bank[pc]`)
- `PROG_DEPTH`, 1024, max words loadable
- `RUN_CYCLES`, 100, watchdog limit in clocks
- `HALT_WORD`, 0, instruction encoding treated as end-of-program
- `HALT_REPEAT`, 4, consecutive `HALT_WORD` fetches that mean halt (>=1)
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  begin load; honoured only in IDLE/DONE
- `s_valid`  in  1  program word valid
- `s_ready`  out  1  loader accepts word
- `s_data`  in  DATA_W  program word
- `s_last`  in  1  final word of program
- `mem_w`  out  1  instruction memory write enable
- `mem_addr`  out  ADDR_W  write address
- `mem_data`  out  DATA_W  write data
- `cpu_rst`  out  1  processor reset
- `cpu_insn`  in  DATA_W  instruction currently fetched
- `busy`  out  1  state is LOAD, RELEASE or RUN
- `done`  out  1  run finished (sticky until `start`/`rst`)
- `timeout`  out  1  run ended by watchdog (sticky)
- `words_loaded`  out  ADDR_W  words written this load
- `cycles`  out  32  clocks spent in RUN

## Operation
- Reset values: state IDLE, `s_ready`=0, `mem_w`=0, `mem_addr`=0, `mem_data`=0, `cpu_rst`=1, `busy`=0, `done`=0, `timeout`=0, `words_loaded`=0, `cycles`=0.
- States: IDLE, LOAD, RELEASE, RUN, DONE.
- IDLE: `start`=1 leads to LOAD and clears `words_loaded`, `cycles`, `done` and `timeout`.
- LOAD:
  - `s_ready`=1.
  - Each beat (`s_valid`&`s_ready`) registers `mem_w`=1, `mem_addr`=`words_loaded`, `mem_data`=`s_data`, then increments `words_loaded`.
  - A beat with `s_last`=1, or the beat at index `PROG_DEPTH`-1, leads to RELEASE.
  - No beat is ever dropped: `s_ready` falls in the same cycle as the transition.
- RELEASE: one cycle; `mem_w`=0, `s_ready`=0, `cpu_rst`=1. Then RUN.
- RUN:
  - `cpu_rst`=0.
  - `cycles` increments every clock and saturates at 2^32-1.
  - Halt counter increments when `cpu_insn`==`HALT_WORD` and clears otherwise.
  - Halt counter reaching `HALT_REPEAT` leads to DONE with `done`=1.
  - `cycles` reaching `RUN_CYCLES` leads to DONE with `done`=1 and `timeout`=1.
  - If halt and watchdog fire in the same cycle, halt wins: `timeout`=0.
- DONE: `cpu_rst`=1 and `busy`=0. `done`, `timeout`, `words_loaded` and `cycles` hold. `start` re-enters LOAD, which reloads from address 0.
- `start` is ignored in LOAD, RELEASE and RUN.
- `rst` in any state returns all outputs to reset values on that edge. A partial load is abandoned and `mem_w` drops in the same edge.

## Timing
- `s_ready` is decoded from state register only; it has no combinational path from `s_valid`.
- Write latency: `mem_w`/`mem_addr`/`mem_data` are valid in the cycle after the accepted beat.
- The last accepted beat is at edge N. RELEASE runs from N+1, and `cpu_rst` falls at edge N+2. First fetch of address 0 is in cycle N+2.
- Halt detection latency: `done` rises one edge after the `HALT_REPEAT`th consecutive halt fetch.
- Timeout: `done`/`timeout` rise at the edge where `cycles` becomes `RUN_CYCLES`.

## Configuration
- `PROG_LOADER_HALT_DETECT_EN` defined: halt detection enabled as above.
- Macro undefined:
  - The halt counter is not built and `HALT_WORD`/`HALT_REPEAT` are unused.
  - RUN always lasts exactly `RUN_CYCLES` clocks.
  - Completion then gives `done`=1 and `timeout`=0, so a fixed-length run is not an error.

## Test plan
- Reset: assert `rst` 2 cycles, then check all outputs at their reset values, `cpu_rst`=1 and `s_ready`=0.
- Load with backpressure:
  - Stimulus: `start`, then 6 words with `s_valid` gaps on beats 2 and 4, `s_last` on word 5. Words are 0x04210000, 0x08420000, 0x0C630000, 0x00110C43, 0xA7C00000, 0x00109084.
  - Response: 6 writes to addresses 0–5 with matching data, `words_loaded`=6, `cpu_rst` falls exactly 2 edges after the last beat.
- Halt (macro on, `HALT_REPEAT`=4): stub processor fetches nonzero words for 7 cycles, then 0 every cycle. Response: `done`=1 at `cycles`=11, `timeout`=0, `cpu_rst`=1.
- Watchdog: `RUN_CYCLES`=100 and `cpu_insn` never zero. Response: `done`=1, `timeout`=1, `cycles`=100. Same test with the macro off: `timeout`=0.
- Depth limit (`PROG_DEPTH`=8): 10 beats offered without `s_last`. Response: exactly 8 accepted, `s_ready` low from beat 9, last write to address 7.
- Reset mid-load, then rerun:
  - `rst` after 3 beats gives reset values with no further `mem_w`.
  - A fresh `start` reloads from address 0.
  - `start` during RUN is ignored.
